// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer defaults, types and linear address helper; NBUF follows FB_DOUBLE_BUFFER_EN
package fb_pkg;
    localparam int FB_WIDTH_DEF = 400;
    localparam int FB_HEIGHT_DEF = 300;
    localparam int COLOR_BITS_DEF = 12;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    typedef logic [COLOR_BITS_DEF-1:0] color_t;
    typedef enum logic {IDLE, PENDING} swap_state_e;
    function automatic int unsigned fb_addr(input logic sel, input int unsigned x, input int unsigned y,
                                            input int unsigned w, input int unsigned h);
        return (sel ? w * h : 32'd0) + y * w + x;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin arbiter; pointer moves past the winner after each grant
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] ptr;
    // Scan from lowest to highest priority so the requester nearest the pointer wins
    always_comb begin
        gnt = '0;
        idx = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (en && req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = PW'((int'(ptr) + k) % N);
            end
        end
    end
    // Advance the pointer past the granted index; hold when nothing is granted
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) ptr <= '0;
        else if (|gnt) ptr <= PW'((int'(idx) + 1) % N);
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one framebuffer RAM port between display scan-out and N_WR writers; FB_DOUBLE_BUFFER_EN enables front/back buffering
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int FB_WIDTH = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int COLOR_BITS = COLOR_BITS_DEF,
    parameter int N_WR = 2,
    parameter int MEM_LATENCY = 1,
    localparam int XW = $clog2(FB_WIDTH),
    localparam int YW = $clog2(FB_HEIGHT),
    localparam int AW = $clog2(NBUF * FB_WIDTH * FB_HEIGHT)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       disp_rd_en_i,
    input  logic [XW-1:0]              disp_rd_x_i,
    input  logic [YW-1:0]              disp_rd_y_i,
    output logic [COLOR_BITS-1:0]      disp_color_o,
    input  logic [N_WR-1:0]            wr_req_i,
    input  logic [N_WR*XW-1:0]         wr_x_i,
    input  logic [N_WR*YW-1:0]         wr_y_i,
    input  logic [N_WR*COLOR_BITS-1:0] wr_color_i,
    output logic [N_WR-1:0]            wr_gnt_o,
    input  logic                       frame_end_i,
    input  logic                       swap_req_i,
    output logic                       swap_done_o,
    output logic                       front_sel_o,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [AW-1:0]              mem_addr_o,
    output logic [COLOR_BITS-1:0]      mem_wdata_o,
    input  logic [COLOR_BITS-1:0]      mem_rdata_i
);
    localparam int PW = (N_WR > 1) ? $clog2(N_WR) : 1;
    swap_state_e swap_st;
    logic wr_sel;
    logic last_v;
    logic [XW-1:0] last_x;
    logic [YW-1:0] last_y;
    logic disp_issue;
    logic [PW-1:0] gidx;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [COLOR_BITS-1:0] wc;
    logic wr_ok;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [MEM_LATENCY-1:0] vpipe;
    logic [COLOR_BITS-1:0] disp_hold;
`ifdef FB_DOUBLE_BUFFER_EN
    logic front_q;
    assign front_sel_o = front_q;
    assign wr_sel = ~front_q;
`else
    assign front_sel_o = 1'b0;
    assign wr_sel = 1'b0;
`endif
    assign disp_issue = disp_rd_en_i && (!last_v || disp_rd_x_i != last_x || disp_rd_y_i != last_y);
    rr_arbiter #(.N(N_WR)) u_rr (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .req     (wr_req_i),
        .en      (!disp_issue && reset_ni),
        .gnt     (wr_gnt_o),
        .idx     (gidx)
    );
    assign wx = wr_x_i[gidx*XW +: XW];
    assign wy = wr_y_i[gidx*YW +: YW];
    assign wc = wr_color_i[gidx*COLOR_BITS +: COLOR_BITS];
    assign wr_ok = |(wr_gnt_o & wr_req_i) && (32'(wx) < FB_WIDTH) && (32'(wy) < FB_HEIGHT);
    assign rd_addr = AW'(fb_addr(front_sel_o, 32'(disp_rd_x_i), 32'(disp_rd_y_i), FB_WIDTH, FB_HEIGHT));
    assign wr_addr = AW'(fb_addr(wr_sel, 32'(wx), 32'(wy), FB_WIDTH, FB_HEIGHT));
    // Register the winning RAM access and remember the last display coordinate issued
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_v      <= 1'b0;
            last_x      <= '0;
            last_y      <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            last_v      <= disp_rd_en_i;
            last_x      <= disp_issue ? disp_rd_x_i : last_x;
            last_y      <= disp_issue ? disp_rd_y_i : last_y;
            mem_en_o    <= disp_issue || wr_ok;
            mem_we_o    <= !disp_issue && wr_ok;
            mem_addr_o  <= disp_issue ? rd_addr : wr_addr;
            mem_wdata_o <= wc;
        end
    end
    // Tag display reads through the RAM latency and keep the last returned pixel
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vpipe     <= '0;
            disp_hold <= '0;
        end else begin
            vpipe     <= (vpipe << 1) | MEM_LATENCY'(mem_en_o & ~mem_we_o);
            disp_hold <= disp_color_o;
        end
    end
    assign disp_color_o = vpipe[MEM_LATENCY-1] ? mem_rdata_i : disp_hold;
    // Swap handshake: a pending request is taken at the next frame end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            swap_st     <= IDLE;
            swap_done_o <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
            front_q     <= 1'b0;
`endif
        end else if (frame_end_i && (swap_st == PENDING || swap_req_i)) begin
            swap_st     <= IDLE;
            swap_done_o <= 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
            front_q     <= ~front_q;
`endif
        end else begin
            swap_st     <= swap_req_i ? PENDING : swap_st;
            swap_done_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: table-driven bench with mem/display scoreboards for fb_port_arbiter
module tb_fb_port_arbiter;
    localparam int XW = 9, YW = 9, CB = 12;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int AW = 18;
    localparam bit DB = 1'b1;
`else
    localparam int AW = 17;
    localparam bit DB = 1'b0;
`endif
    typedef struct {
        logic en; int x; int y; logic [1:0] req; int wx0; int wy0; int wx1; int wy1;
        logic fe; logic sr; logic rd; logic [1:0] gnt; logic front; logic done;
    } vec_t;
    typedef struct { logic en; logic we; int addr; logic [11:0] d; } mexp_t;
    typedef struct { int due; logic [11:0] d; } dexp_t;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic disp_rd_en_i = 1'b0;
    logic [XW-1:0] disp_rd_x_i = '0;
    logic [YW-1:0] disp_rd_y_i = '0;
    logic [CB-1:0] disp_color_o;
    logic [1:0] wr_req_i = '0;
    logic [2*XW-1:0] wr_x_i = '0;
    logic [2*YW-1:0] wr_y_i = '0;
    logic [2*CB-1:0] wr_color_i = '0;
    logic [1:0] wr_gnt_o;
    logic frame_end_i = 1'b0;
    logic swap_req_i = 1'b0;
    logic swap_done_o, front_sel_o, mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [CB-1:0] mem_wdata_o;
    logic [CB-1:0] mem_rdata_i = '0;

    int checks = 0, failures = 0, cyc = 0;
    logic [11:0] exp_color = '0;
    logic front_db = 1'b0, front_now = 1'b0;
    mexp_t mq[$];
    dexp_t dq[$];

    always #5 clk = ~clk;

    fb_port_arbiter dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .disp_rd_en_i(disp_rd_en_i), .disp_rd_x_i(disp_rd_x_i), .disp_rd_y_i(disp_rd_y_i),
        .disp_color_o(disp_color_o),
        .wr_req_i(wr_req_i), .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_color_i(wr_color_i),
        .wr_gnt_o(wr_gnt_o),
        .frame_end_i(frame_end_i), .swap_req_i(swap_req_i), .swap_done_o(swap_done_o),
        .front_sel_o(front_sel_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [11:0] ram_val(input int a);
        return 12'((a * 37 + 5) ^ (a >> 3)) | 12'h001;
    endfunction

    // Synchronous-read RAM stub, one cycle latency
    always @(posedge clk) if (mem_en_o && !mem_we_o) mem_rdata_i <= ram_val(int'(mem_addr_o));

    function automatic int lin(input logic sel, input int x, input int y);
        return ((DB && sel) ? 120000 : 0) + y * 400 + x;
    endfunction

    function automatic vec_t v(input logic en, input int x, input int y, input logic [1:0] req,
                               input int wx0, input int wy0, input int wx1, input int wy1,
                               input logic fe, input logic sr, input logic rd, input logic [1:0] gnt,
                               input logic front, input logic done);
        vec_t r;
        r = '{en, x, y, req, wx0, wy0, wx1, wy1, fe, sr, rd, gnt, front, done};
        return r;
    endfunction

    function automatic vec_t idle();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, front_db, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        mexp_t m;
        logic k;
        int wx, wy;
        disp_rd_en_i = t.en;
        disp_rd_x_i = XW'(t.x);
        disp_rd_y_i = YW'(t.y);
        wr_req_i = t.req;
        wr_x_i = {XW'(t.wx1), XW'(t.wx0)};
        wr_y_i = {YW'(t.wy1), YW'(t.wy0)};
        wr_color_i = {12'(12'hB00 + cyc), 12'(12'hA00 + cyc)};
        frame_end_i = t.fe;
        swap_req_i = t.sr;
        #1;
        chk("gnt", 32'(wr_gnt_o), 32'(t.gnt));
        m = '{1'b0, 1'b0, 0, 12'h0};
        if (t.rd) begin
            m = '{1'b1, 1'b0, lin(front_now, t.x, t.y), 12'h0};
            dq.push_back('{cyc + 2, ram_val(lin(front_now, t.x, t.y))});
        end else if (t.gnt != 0) begin
            k = t.gnt[1];
            wx = k ? t.wx1 : t.wx0;
            wy = k ? t.wy1 : t.wy0;
            if (wx < 400 && wy < 300)
                m = '{1'b1, 1'b1, lin(~front_now, wx, wy), k ? 12'(12'hB00 + cyc) : 12'(12'hA00 + cyc)};
        end
        mq.push_back(m);
        @(posedge clk);
        #1;
        cyc++;
        m = mq.pop_front();
        chk("mem_en", 32'(mem_en_o), 32'(m.en));
        chk("mem_we", 32'(mem_we_o), 32'(m.we));
        if (m.en) chk("mem_addr", 32'(mem_addr_o), m.addr);
        if (m.we) chk("mem_wdata", 32'(mem_wdata_o), 32'(m.d));
        if (dq.size() > 0 && dq[0].due == cyc) exp_color = dq.pop_front().d;
        chk("disp_color", 32'(disp_color_o), 32'(exp_color));
        front_db = t.front;
        front_now = DB ? t.front : 1'b0;
        chk("front_sel", 32'(front_sel_o), 32'(front_now));
        chk("swap_done", 32'(swap_done_o), 32'(t.done));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(wr_gnt_o), 0);
        chk({tag, "_mem_en"}, 32'(mem_en_o), 0);
        chk({tag, "_mem_we"}, 32'(mem_we_o), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata_o), 0);
        chk({tag, "_disp"}, 32'(disp_color_o), 0);
        chk({tag, "_front"}, 32'(front_sel_o), 0);
        chk({tag, "_done"}, 32'(swap_done_o), 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t s;
        repeat (3) @(posedge clk);
        #1;
        wr_req_i = 2'b11;
        #1;
        chk_zero("reset");
        wr_req_i = 2'b00;
        reset_ni = 1'b1;
        // display only: (0,0) twice, (1,0), disable, re-enable on same address
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // both writers, display idle: alternate 0,1,0,1
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 0, 0, 3, 3, 4, 5, 6, 0, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0));
        // display changes every second cycle while both writers request
        tbl.push_back(v(1, 10, 1, 3, 3, 4, 5, 6, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(v(1, 10, 1, 3, 3, 4, 5, 6, 0, 0, 0, 2'b01, 0, 0));
        tbl.push_back(v(1, 11, 1, 3, 3, 4, 5, 6, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(v(1, 11, 1, 3, 3, 4, 5, 6, 0, 0, 0, 2'b10, 0, 0));
        tbl.push_back(v(1, 12, 1, 3, 3, 4, 5, 6, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(v(1, 12, 1, 3, 3, 4, 5, 6, 0, 0, 0, 2'b01, 0, 0));
        // range boundaries: dropped writes still granted, last pixel written
        tbl.push_back(v(0, 0, 0, 1, 400, 5, 0, 0, 0, 0, 0, 2'b01, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 5, 300, 0, 0, 0, 2'b10, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 399, 299, 0, 0, 0, 0, 0, 2'b01, 0, 0));
        // swap: request, absorbed repeat, frame end with a write on the swap edge
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 7, 8, 0, 0, 1, 0, 0, 2'b01, 1, 1));
        tbl.push_back(v(1, 2, 2, 2, 0, 0, 9, 9, 0, 0, 1, 2'b00, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 9, 9, 0, 0, 0, 2'b10, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) apply(tbl[i]);
        // swap request 40 cycles before frame end: single done pulse at the toggle
        for (int i = 0; i <= 40; i++) begin
            s = idle();
            s.sr = (i == 0);
            s.fe = (i == 40);
            s.front = (i == 40) ? ~front_db : front_db;
            s.done = (i == 40);
            apply(s);
        end
        apply(idle());
        apply(idle());
        // reset while a display read is returning
        apply(v(1, 20, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, front_db, 0));
        disp_rd_en_i = 1'b0;
        wr_req_i = 2'b11;
        @(posedge clk);
        #1;
        reset_ni = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        wr_req_i = 2'b00;
        mq.delete();
        dq.delete();
        exp_color = '0;
        front_db = 1'b0;
        front_now = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("disp_after_rst", 32'(disp_color_o), 0);
        end
        apply(v(1, 20, 3, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
        apply(v(0, 0, 0, 3, 3, 4, 5, 6, 0, 0, 0, 2'b01, 0, 0));
        apply(idle());
        apply(idle());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares one single-port framebuffer RAM between the display scan-out path and N_WR draw-side writers. It also owns front/back buffer selection. It sits between the video controller's pixel-read port and the framebuffer memory. The display always wins a memory slot, but a read is issued only when the display address changes, so writers get the cycles the scan-out leaves free. Writers are served round-robin.

## Interface
- FB_WIDTH, 400, framebuffer width in pixels (x range 0..FB_WIDTH-1)
- FB_HEIGHT, 300, framebuffer height in pixels
- COLOR_BITS, 12, pixel word width
- N_WR, 2, number of writer ports (1..8)
- MEM_LATENCY, 1, RAM read latency in cycles (≥1)
- Derived: XW=$clog2(FB_WIDTH), YW=$clog2(FB_HEIGHT), AW=$clog2(NBUF*FB_WIDTH*FB_HEIGHT), NBUF=2 with FB_DOUBLE_BUFFER_EN, else 1
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous, active-low reset
- disp_rd_en_i  in  1  display wants pixel data this cycle
- disp_rd_x_i / disp_rd_y_i  in  XW / YW  display pixel coordinate
- disp_color_o  out  COLOR_BITS  pixel at requested coordinate, DISP_LATENCY=MEM_LATENCY+1 cycles after presentation
- wr_req_i  in  N_WR  per-writer request (valid)
- wr_x_i / wr_y_i  in  N_WR×XW / N_WR×YW  write coordinates, packed
- wr_color_i  in  N_WR×COLOR_BITS  write data, packed
- wr_gnt_o  out  N_WR  one-hot grant; a transfer occurs when wr_req_i[i] & wr_gnt_o[i]
- frame_end_i  in  1  one-cycle pulse at the start of vertical blanking
- swap_req_i  in  1  one-cycle pulse requesting a buffer swap
- swap_done_o  out  1  one-cycle pulse: swap taken
- front_sel_o  out  1  buffer currently scanned out
- mem_en_o, mem_we_o  out  1, 1  RAM enable, write enable (registered)
- mem_addr_o  out  AW  RAM address (registered)
- mem_wdata_o  out  COLOR_BITS  RAM write data (registered)
- mem_rdata_i  in  COLOR_BITS  RAM read data

## Operation
- Linear address = sel·FB_WIDTH·FB_HEIGHT + y·FB_WIDTH + x. Display reads use sel=front_sel. Writes use sel=~front_sel.
- Display slot: a read is issued when disp_rd_en_i=1 and (x,y) differs from the last issued display address, or on the first enabled cycle after reset or after disp_rd_en_i was low. A writer may take the cycle in any other case.
- Writer grant is combinational in the same cycle. At most one grant per cycle, and only when the display does not take the slot. Priority is round-robin: the pointer moves to (granted index + 1) mod N_WR after each transfer and holds when there is no grant.
- Out-of-range writes (x≥FB_WIDTH or y≥FB_HEIGHT) are granted and dropped, with mem_we_o=0 and mem_en_o=0.
- Read return: a valid-bit shift register of length MEM_LATENCY tags display reads. disp_color_o captures mem_rdata_i when a tagged read returns and holds its value otherwise. Repeated addresses therefore produce correct data at the same latency.
- Swap FSM:
  - States: IDLE → PENDING on swap_req_i.
  - PENDING → IDLE on frame_end_i: front_sel toggles and swap_done_o pulses one cycle later.
  - swap_req_i and frame_end_i in the same cycle from IDLE: the swap is taken at that edge.
  - swap_req_i while PENDING: absorbed.

## Timing
- Reset values: front_sel_o=0, swap FSM=IDLE, RR pointer=0, valid pipe=0, disp_color_o=0, mem_*_o=0, swap_done_o=0, wr_gnt_o=0.
- Reset mid-operation clears in-flight read tags, so late RAM data is ignored.
- Write: RAM write occurs on the edge after the transfer cycle (mem_* registered).
- Display: coordinate presented at cycle t appears on disp_color_o at cycle t+1+MEM_LATENCY.
- Swap: front_sel_o changes on the edge after frame_end_i. Display reads from that cycle onward use the new buffer.
- Writers issued in the same cycle as the swap edge use the old ~front_sel. The RAM address is computed from the pre-edge value.

## Configuration
- FB_DOUBLE_BUFFER_EN defined: NBUF=2 and the swap FSM behaves as above.
- FB_DOUBLE_BUFFER_EN undefined: NBUF=1 and front_sel_o is tied to 0. Reads and writes address the single buffer. The FSM is kept, so swap_done_o still pulses one cycle after frame_end_i when a swap is pending, and software handshakes are unchanged.

## Structure
- Package fb_pkg holds:
  - FB_WIDTH/FB_HEIGHT/COLOR_BITS defaults
  - color_t typedef
  - swap_state_e enum (IDLE, PENDING)
  - fb_addr() function computing the linear address
- Sub-module rr_arbiter: N_WR-wide round-robin, with inputs req and enable, outputs one-hot gnt, and an internal pointer.

## Test plan
- Display only, disp (0,0) held 2 cycles then (1,0): exactly two mem reads at addr 0 and 1. disp_color_o equals RAM contents at t+2 (MEM_LATENCY=1).
- Both writers requesting continuously, display idle: grants alternate 0,1,0,1. Each transfer produces mem_we_o=1 on the next cycle at the back-buffer address, 120000+y·400+x.
- Display changes address every 2nd cycle while both writers request: writers get exactly the alternate cycles, and no grant occurs in a display-read cycle.
- swap_req_i at cycle 10, frame_end_i at cycle 50: front_sel_o 0→1 at cycle 51 and swap_done_o=1 at cycle 51 only. Same-cycle swap_req_i+frame_end_i also swaps.
- Write to (400,5): wr_gnt_o=1 and no memory write.
- Assert reset_ni mid-read: all outputs 0 asynchronously. The RAM return after release does not update disp_color_o. With FB_DOUBLE_BUFFER_EN undefined, front_sel_o stays 0 and swap_done_o still pulses.
